rf_wport_arbiter: RTL
=====================

Name: rf_wport_arbiter

Overview:
- Sequences the single write port of the 32x32 register file between two requesters:
  - the in-order pipeline writeback stage (WB);
  - a multi-cycle execution unit (MC, e.g. divider or load miss path).
- WB has priority. MC results wait in a small FIFO.
- Maintains a per-register busy mask so decode can stall on RAW/WAW hazards against pending MC writes.
- Drives a registered write port into the register file.

Parameters:
- DW, 32: data width.
- AW, 5: register index width (2^AW registers).
- QDEPTH, 2: MC result FIFO depth (power of two, >=2).
- STARVE, 4: cycles a non-empty FIFO head may wait before wb_stall is raised.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- wb_we  in  1  WB write request; always accepted, no backpressure.
- wb_rd  in  AW  WB destination register.
- wb_data  in  DW  WB write data.
- mc_valid  in  1  MC result valid.
- mc_rd  in  AW  MC destination register.
- mc_data  in  DW  MC result data.
- mc_ready  out  1  FIFO can accept the MC result this cycle.
- wb_stall  out  1  registered request to the pipeline to hold off writeback.
- busy_mask  out  2^AW  bit r=1 while an MC write to register r is pending.
- rf_we  out  1  register-file write enable (registered).
- rf_rd  out  AW  register-file write index (registered).
- rf_wdata  out  DW  register-file write data (registered).

Behaviour:
- Reset (rst=0 at a rising edge):
  - FIFO emptied, starve counter 0, busy_mask 0, wb_stall 0.
  - rf_we 0, rf_rd 0, rf_wdata 0.
  - mc_ready is forced 0 combinationally while rst=0.
  - A reset mid-operation discards all queued MC results; no write is issued for them.
- Acceptance:
  - mc_ready = rst && (count < QDEPTH) && !busy_mask[mc_rd]. It does not depend on a pop in the same cycle.
  - Handshake: mc_valid && mc_ready.
  - Accepted entry with mc_rd=0 is discarded: not enqueued, busy unchanged.
  - Otherwise the entry is enqueued at the tail and busy_mask[mc_rd] is set at that edge.
- Grant, evaluated each cycle:
  - wb_we && wb_rd!=0 → WB granted.
  - else FIFO non-empty → head popped and granted.
  - else idle.
  - WB with wb_rd=0 is treated as no request.
- Output latency:
  - The granted request appears on rf_we/rf_rd/rf_wdata at the next edge, i.e. 1-cycle latency.
  - Idle → rf_we=0; rf_rd/rf_wdata hold their previous values.
- Busy clear:
  - busy_mask[r] for a popped entry clears one edge after rf_we=1 with rf_rd=r, i.e. after the register file has captured the data.
  - Decode never sees a stale read on a cleared register.
  - Set and clear of the same bit in the same cycle cannot occur, because mc_ready blocks duplicate rd.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged.
  - Push while full: impossible (mc_ready=0).
  - Pointer wrap-around modulo QDEPTH.
- Starvation:
  - Starve counter increments each cycle the FIFO is non-empty and no pop occurs (saturating at STARVE).
  - Counter resets to 0 on any pop or when the FIFO is empty.
  - wb_stall <= (counter_next >= STARVE) && FIFO non-empty after this cycle.
  - The pipeline guarantees wb_we=0 in any cycle wb_stall=1, so the head then wins.
  - If wb_we=1 arrives anyway, WB still wins and wb_stall stays asserted.
- Ordering:
  - The arbiter does not reorder WB relative to MC.
  - WAW/RAW safety relies on decode stalling on busy_mask.

Test Plan:
- Reset: drive rst=0 for 2 cycles with mc_valid=1, wb_we=1 → rf_we=0, busy_mask=0, mc_ready=0, wb_stall=0. Release → mc_ready=1.
- MC only: accept mc_rd=7, mc_data=0xDEADBEEF at cycle 0 → busy_mask[7]=1 from cycle 1; rf_we=1, rf_rd=7, rf_wdata=0xDEADBEEF at cycle 2; busy_mask[7]=0 from cycle 3.
- Conflict: same-cycle wb_we (rd=3, 0x11) and queued head (rd=9, 0x22) → rf writes rd=3 first, rd=9 the following cycle.
- Fill and backpressure:
  - Continuous WB traffic to rd=1.
  - Push MC rd=4, then rd=5 → mc_ready=0 (full). A third push with rd=6 is held.
  - mc_rd=4 presented again while busy → mc_ready=0.
- Starvation: FIFO holds one entry, wb_we=1 every cycle → wb_stall=1 after 4 waiting cycles. Drop wb_we → head written next cycle; wb_stall=0 after the pop.
- Corner cases:
  - mc_rd=0 accepted → no busy bit set, no rf write.
  - wb_rd=0 with FIFO non-empty → FIFO head granted.
  - rst=0 asserted with 2 entries queued → no rf_we for them; busy_mask=0.

Source files
------------

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: WB has priority, MC results queue in a
// small FIFO, a busy mask flags registers with pending MC writes, and a
// starvation counter raises wb_stall so a waiting FIFO head eventually wins.
module rf_wport_arbiter #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int QDEPTH = 2,
    parameter int STARVE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_we,
    input  logic [AW-1:0]        wb_rd,
    input  logic [DW-1:0]        wb_data,
    input  logic                 mc_valid,
    input  logic [AW-1:0]        mc_rd,
    input  logic [DW-1:0]        mc_data,
    output logic                 mc_ready,
    output logic                 wb_stall,
    output logic [(1<<AW)-1:0]   busy_mask,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_rd,
    output logic [DW-1:0]        rf_wdata
);

    localparam int NREG = 1 << AW;
    localparam int PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW   = $clog2(QDEPTH + 1);
    localparam int SW   = $clog2(STARVE + 1);

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t            fifo_q [QDEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            stall_q, stall_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            rf_we_q, rf_we_d;
    logic            rf_mc_q, rf_mc_d;   // current rf write came from the FIFO
    logic [AW-1:0]   rf_rd_q, rf_rd_d;
    logic [DW-1:0]   rf_wdata_q, rf_wdata_d;

    logic wb_req, empty, push, pop;
    ent_t head;

    // Acceptance, grant selection and next-state for all arbiter state
    always_comb begin
        wb_req   = wb_we && (wb_rd != '0);
        empty    = (cnt_q == '0);
        head     = fifo_q[rd_ptr_q];
        mc_ready = rst && (cnt_q < CW'(QDEPTH)) && !busy_q[mc_rd];
        // r0 results are accepted but dropped: nothing to write, nothing to track
        push     = mc_valid && mc_ready && (mc_rd != '0);
        pop      = !wb_req && !empty;

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);

        if (pop || empty)
            starve_d = '0;
        else if (starve_q < SW'(STARVE))
            starve_d = starve_q + SW'(1);
        else
            starve_d = starve_q;
        stall_d = (starve_d >= SW'(STARVE)) && (cnt_d != '0);

        // Clear only once the register file has captured the MC data
        busy_d = busy_q;
        if (rf_we_q && rf_mc_q)
            busy_d[rf_rd_q] = 1'b0;
        if (push)
            busy_d[mc_rd] = 1'b1;

        rf_we_d    = 1'b0;
        rf_mc_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        if (wb_req) begin
            rf_we_d    = 1'b1;
            rf_rd_d    = wb_rd;
            rf_wdata_d = wb_data;
        end else if (pop) begin
            rf_we_d    = 1'b1;
            rf_mc_d    = 1'b1;
            rf_rd_d    = head.rd;
            rf_wdata_d = head.data;
        end
    end

    // Control state and registered write port
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            starve_q   <= '0;
            stall_q    <= 1'b0;
            busy_q     <= '0;
            rf_we_q    <= 1'b0;
            rf_mc_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            stall_q    <= stall_d;
            busy_q     <= busy_d;
            rf_we_q    <= rf_we_d;
            rf_mc_q    <= rf_mc_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // FIFO storage; contents are meaningless while the count says empty
    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr_q] <= '{rd: mc_rd, data: mc_data};
    end

    assign wb_stall  = stall_q;
    assign busy_mask = busy_q;
    assign rf_we     = rf_we_q;
    assign rf_rd     = rf_rd_q;
    assign rf_wdata  = rf_wdata_q;

endmodule
